// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types, widths and helpers for the shared-multiplier arbiter.
//   OP_W    operand width fed to the multiplier
//   RES_W   product width returned to requesters
//   state_e controller states
//   clog2   index width helper (returns 0 for v <= 1)
package mul_arb_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mul_rr_pick.sv
// mul_rr_pick: combinational round-robin picker.
//   req_i   request vector, one bit per requester
//   ptr_i   index of the last winner; search starts at ptr_i+1 (mod NREQ)
//   gnt_c   one-hot grant (zero when no request)
//   idx_c   index of the winner (zero when no request)
//   any_c   at least one request present
module mul_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_c,
  output logic [ID_W-1:0] idx_c,
  output logic            any_c
);

  // Walk NREQ positions starting just after the pointer; first hit wins.
  always_comb begin
    int unsigned pos;
    logic [ID_W-1:0] cand;
    pos   = 0;
    cand  = '0;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      pos  = (32'(ptr_i) + off) % NREQ;
      cand = ID_W'(pos);
      if (!any_c && req_i[cand]) begin
        any_c = 1'b1;
        idx_c = cand;
      end
    end
    if (any_c) gnt_c[idx_c] = 1'b1;
  end

endmodule

// File: rtl/multiplier.sv
// multiplier: existing unsigned 8x8 -> 16 combinational multiplier datapath.
//   A, B    8-bit operands
//   result  16-bit unsigned product
module multiplier (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] result
);

  assign result = 16'(A) * 16'(B);

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one 8x8 multiplier among NREQ requesters, round-robin.
//   clk, rst_n  clock, async active-low reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept (combinational, one-hot or zero, IDLE only)
//   req_a/req_b packed 8-bit operands, requester i at [8i+7:8i]
//   rsp_valid   response valid (held until rsp_ready)
//   rsp_ready   response consumer ready
//   rsp_id      index of the requester served
//   rsp_result  16-bit product from the multiplier
//   busy        high whenever the controller is not IDLE
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned LAT  = 1,
  localparam int unsigned ID_W = clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OP_W*NREQ-1:0] req_a,
  input  logic [OP_W*NREQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [RES_W-1:0]     rsp_result,
  output logic                 busy
);

  localparam int unsigned CNT_W = (clog2(LAT + 1) < 1) ? 1 : clog2(LAT + 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    op_a_q, op_a_d;
  logic [OP_W-1:0]    op_b_q, op_b_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  logic [NREQ-1:0]    pick_gnt_c;
  logic [ID_W-1:0]    pick_idx_c;
  logic               pick_any_c;
  logic [RES_W-1:0]   mul_res_c;

  mul_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  // Multiplier sees only the operand registers, so its inputs stay stable in CALC.
  multiplier u_mul (
    .A      (op_a_q),
    .B      (op_b_q),
    .result (mul_res_c)
  );

  // Next-state, datapath capture and the combinational accept.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          // rst_n gating keeps req_ready low throughout reset.
          req_ready = rst_n ? pick_gnt_c : '0;
          op_a_d    = req_a[OP_W*int'(pick_idx_c) +: OP_W];
          op_b_d    = req_b[OP_W*int'(pick_idx_c) +: OP_W];
          rsp_id_d  = pick_idx_c;
          ptr_d     = pick_idx_c;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(LAT - 1)) begin
          rsp_result_d = mul_res_c;
          cnt_d        = '0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= ID_W'(NREQ - 1);
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed, table-driven bench for mul_arbiter (NREQ=4, LAT=1).
// Inputs are driven at the falling edge; outputs are sampled 1ns later.
module tb_mul_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mul_arbiter #(
    .NREQ (NREQ),
    .LAT  (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [1:0]  exp_id;
    logic [15:0] exp_res;
    logic        exp_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] er, input logic erv, input logic [1:0] eid,
                              input logic [15:0] eres, input logic eb);
    vec_t r;
    r.valid = v; r.a = a; r.b = b; r.exp_ready = er; r.exp_rv = erv;
    r.exp_id = eid; r.exp_res = eres; r.exp_busy = eb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for rsp_valid, checking the current cycle first.
  task automatic wait_rsp(input string name, input logic [1:0] eid, input logic [15:0] eres);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      if (rsp_valid) begin
        found = 1'b1;
        chk({name, " id"}, 32'(rsp_id), 32'(eid));
        chk({name, " result"}, 32'(rsp_result), 32'(eres));
      end
    end
    chk({name, " rsp timeout"}, 32'(found), 32'd1);
  endtask

  // Waits (bounded) for a non-zero req_ready and checks it.
  task automatic wait_grant(input string name, input logic [3:0] eready);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      if (req_ready != 4'b0) begin
        found = 1'b1;
        chk({name, " ready"}, 32'(req_ready), 32'(eready));
      end
    end
    chk({name, " grant timeout"}, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  fair_seq [4];
    logic [15:0] fair_res [4];
    int ng;
    int nr;

    // Contention (A=i+1, B=15), then a single request 2*3 from requester 0.
    vq.push_back(mk(4'b1111, 32'h04030201, 32'h0F0F0F0F, 4'b0001, 1'b0, 2'd0, 16'h0000, 1'b0));
    vq.push_back(mk(4'b1110, 32'h04030201, 32'h0F0F0F0F, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1110, 32'h04030201, 32'h0F0F0F0F, 4'b0000, 1'b1, 2'd0, 16'h000F, 1'b1));
    vq.push_back(mk(4'b1110, 32'h04030201, 32'h0F0F0F0F, 4'b0010, 1'b0, 2'd0, 16'h0000, 1'b0));
    vq.push_back(mk(4'b1100, 32'h04030201, 32'h0F0F0F0F, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1100, 32'h04030201, 32'h0F0F0F0F, 4'b0000, 1'b1, 2'd1, 16'h001E, 1'b1));
    vq.push_back(mk(4'b1100, 32'h04030201, 32'h0F0F0F0F, 4'b0100, 1'b0, 2'd0, 16'h0000, 1'b0));
    vq.push_back(mk(4'b1000, 32'h04030201, 32'h0F0F0F0F, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1000, 32'h04030201, 32'h0F0F0F0F, 4'b0000, 1'b1, 2'd2, 16'h002D, 1'b1));
    vq.push_back(mk(4'b1000, 32'h04030201, 32'h0F0F0F0F, 4'b1000, 1'b0, 2'd0, 16'h0000, 1'b0));
    vq.push_back(mk(4'b0000, 32'h04030201, 32'h0F0F0F0F, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b1));
    vq.push_back(mk(4'b0000, 32'h04030201, 32'h0F0F0F0F, 4'b0000, 1'b1, 2'd3, 16'h003C, 1'b1));
    vq.push_back(mk(4'b0000, 32'h04030201, 32'h0F0F0F0F, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b0));
    vq.push_back(mk(4'b0001, 32'h00000002, 32'h00000003, 4'b0001, 1'b0, 2'd0, 16'h0000, 1'b0));
    vq.push_back(mk(4'b0000, 32'h00000002, 32'h00000003, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b1));
    vq.push_back(mk(4'b0000, 32'h00000002, 32'h00000003, 4'b0000, 1'b1, 2'd0, 16'h0006, 1'b1));
    vq.push_back(mk(4'b0000, 32'h00000002, 32'h00000003, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b0));

    // Reset with every requester valid.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = 32'h04030201;
    req_b     = 32'h0F0F0F0F;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    chk("reset rsp_result", 32'(rsp_result), 32'd0);

    // Release reset in the first vector cycle and step the table.
    for (int i = 0; i < int'(vq.size()); i++) begin
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = vq[i].valid;
      req_a     = vq[i].a;
      req_b     = vq[i].b;
      rsp_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vq[i].exp_ready));
      chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vq[i].exp_rv));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vq[i].exp_busy));
      if (vq[i].exp_rv) begin
        chk($sformatf("vec%0d rsp_id", i), 32'(rsp_id), 32'(vq[i].exp_id));
        chk($sformatf("vec%0d rsp_result", i), 32'(rsp_result), 32'(vq[i].exp_res));
      end
    end

    // Backpressure: requester 1 (15*15) held 5 cycles, requester 3 (7*9) waiting.
    @(negedge clk);
    req_valid = 4'b1010;
    req_a     = {8'd7, 8'd0, 8'd15, 8'd0};
    req_b     = {8'd9, 8'd0, 8'd15, 8'd0};
    rsp_ready = 1'b0;
    #1;
    chk("bp grant 1", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    chk("bp calc ready", 32'(req_ready), 32'd0);
    chk("bp calc rsp_valid", 32'(rsp_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp hold%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp hold%0d rsp_id", k), 32'(rsp_id), 32'd1);
      chk($sformatf("bp hold%0d rsp_result", k), 32'(rsp_result), 32'h00E1);
      chk($sformatf("bp hold%0d req_ready", k), 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp release rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp release req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("bp next grant 3", 32'(req_ready), 32'b1000);
    chk("bp idle busy", 32'(busy), 32'd0);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    wait_rsp("bp req3", 2'd3, 16'h003F);

    // Fairness: requesters 0 (5*5) and 2 (6*7) held valid continuously.
    fair_seq[0] = 2'd0; fair_seq[1] = 2'd2; fair_seq[2] = 2'd0; fair_seq[3] = 2'd2;
    fair_res[0] = 16'd25; fair_res[1] = 16'd42; fair_res[2] = 16'd25; fair_res[3] = 16'd42;
    ng = 0;
    nr = 0;
    @(negedge clk);
    req_valid = 4'b0101;
    req_a     = {8'd0, 8'd6, 8'd0, 8'd5};
    req_b     = {8'd0, 8'd7, 8'd0, 8'd5};
    for (int c = 0; c < 40 && nr < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (ng >= 4) req_valid = 4'b0000;
      #1;
      if (req_ready != 4'b0 && ng < 4) begin
        chk($sformatf("fair grant%0d", ng), 32'(req_ready), 32'd1 << fair_seq[ng]);
        ng++;
      end
      if (rsp_valid && nr < 4) begin
        chk($sformatf("fair rsp%0d id", nr), 32'(rsp_id), 32'(fair_seq[nr]));
        chk($sformatf("fair rsp%0d result", nr), 32'(rsp_result), 32'(fair_res[nr]));
        nr++;
      end
    end
    chk("fair grant count", 32'(ng), 32'd4);
    chk("fair rsp count", 32'(nr), 32'd4);

    // Reset one cycle after accepting requester 2 (3*3); that result must never appear.
    @(negedge clk);
    req_valid = 4'b0100;
    req_a     = {8'd0, 8'd3, 8'd0, 8'd5};
    req_b     = {8'd0, 8'd3, 8'd0, 8'd5};
    #1;
    chk("rst grant 2", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = 4'b0101;
    rst_n     = 1'b0;
    #1;
    chk("rst mid ready", 32'(req_ready), 32'd0);
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rst held ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst release grant 0", 32'(req_ready), 32'b0001);
    chk("rst release rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    chk("rst no stale rsp", 32'(rsp_valid), 32'd0);
    chk("rst calc busy", 32'(busy), 32'd1);
    @(negedge clk);
    wait_rsp("rst req0", 2'd0, 16'd25);
    @(negedge clk);
    wait_grant("rst pending 2", 4'b0100);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    wait_rsp("rst req2", 2'd2, 16'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
